// File: rtl/mac_channel_scheduler_if.sv
// Valid/ready stream bundle used for the window input and result output.
// master drives data/valid and samples ready; slave does the reverse.
interface mac_channel_scheduler_if #(
  parameter int W = 8
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/mac_channel_scheduler.sv
// Shares one MAC pixel engine across NUM_CH channels; owns the kernel bank.
// Ports: win (window stream in), out (result word stream out), wr_* (kernel
// bank writes, wr_drop_o pulses on a refused write), mac_* (MAC engine side),
// busy_o (not idle).
module mac_channel_scheduler #(
  parameter int DATA_RES    = 8,
  parameter int WEIGHT_RES  = 8,
  parameter int KERNEL_SIZE = 9,
  parameter int NUM_CH      = 4
) (
  input  logic clk_i,
  input  logic resetn_i,

  mac_channel_scheduler_if.slave win,

  input  logic                                  wr_en_i,
  input  logic [$clog2(NUM_CH)-1:0]             wr_ch_i,
  input  logic [WEIGHT_RES*(KERNEL_SIZE+1)-1:0] wr_kernel_i,
  output logic                                  wr_drop_o,

  output logic [WEIGHT_RES*(KERNEL_SIZE+1)-1:0] mac_kernel_o,
  output logic [DATA_RES*KERNEL_SIZE-1:0]       mac_grid_o,
  output logic                                  mac_valid_o,
  input  logic [DATA_RES-1:0]                   mac_pixel_i,
  input  logic                                  mac_pixel_valid_i,

  mac_channel_scheduler_if.master out,

  output logic busy_o
);

  localparam int KW = WEIGHT_RES*(KERNEL_SIZE+1);
  localparam int CW = $clog2(NUM_CH);
  localparam int NW = $clog2(NUM_CH+1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    HOLD
  } state_t;

  state_t          state;
  logic [KW-1:0]   bank [NUM_CH];
  logic [CW-1:0]   iss_cnt;
  logic [NW-1:0]   res_cnt;

  logic            wr_ok;
  logic            accept;
  logic            res_take;
  logic            res_full;
  logic [KW-1:0]   k0_fwd;

  assign wr_ok = wr_en_i && (state == IDLE)
              && (int'(wr_ch_i) < NUM_CH);

  assign accept = win.valid && win.ready;

  assign res_take = mac_pixel_valid_i
                 && (state == ISSUE || state == DRAIN)
                 && (res_cnt < NW'(NUM_CH));

  assign res_full = (res_cnt == NW'(NUM_CH))
                 || (res_take && res_cnt == NW'(NUM_CH-1));

  // A write in the accept cycle must already reach channel 0's issue.
  assign k0_fwd = (wr_ok && wr_ch_i == '0) ? wr_kernel_i : bank[0];

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int c = 0; c < NUM_CH; c++) bank[c] <= '0;
      wr_drop_o <= 1'b0;
    end else begin
      wr_drop_o <= wr_en_i && !wr_ok;
      if (wr_ok) bank[wr_ch_i] <= wr_kernel_i;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state        <= IDLE;
      win.ready    <= 1'b0;
      busy_o       <= 1'b0;
      mac_valid_o  <= 1'b0;
      mac_kernel_o <= '0;
      mac_grid_o   <= '0;
      out.valid    <= 1'b0;
      out.data     <= '0;
      iss_cnt      <= '0;
      res_cnt      <= '0;
    end else begin
      if (res_take) begin
        out.data[res_cnt*DATA_RES +: DATA_RES] <= mac_pixel_i;
        res_cnt <= res_cnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          win.ready <= 1'b1;
          if (accept) begin
            state        <= ISSUE;
            win.ready    <= 1'b0;
            busy_o       <= 1'b1;
            mac_grid_o   <= win.data;
            mac_kernel_o <= k0_fwd;
            iss_cnt      <= '0;
            res_cnt      <= '0;
          end
        end
        // Kernel k is presented one cycle before its grid beat.
        ISSUE: begin
          mac_valid_o <= 1'b1;
          iss_cnt     <= iss_cnt + 1'b1;
          if (iss_cnt == CW'(NUM_CH-1)) state <= DRAIN;
          else mac_kernel_o <= bank[iss_cnt + 1'b1];
        end
        DRAIN: begin
          mac_valid_o <= 1'b0;
          if (res_full) begin
            state     <= HOLD;
            out.valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out.ready) begin
            state     <= IDLE;
            out.valid <= 1'b0;
            busy_o    <= 1'b0;
            win.ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_channel_scheduler.sv
// Scoreboard bench for mac_channel_scheduler with a 3-cycle MAC model.
// Expected words come from a channel-by-channel reference of the kernel bank.
module tb_mac_channel_scheduler;

  localparam int DR = 8;
  localparam int WR = 8;
  localparam int KS = 9;
  localparam int NC = 4;
  localparam int KW = WR*(KS+1);
  localparam int GW = DR*KS;
  localparam int OW = DR*NC;
  localparam int CW = $clog2(NC);

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mac_channel_scheduler_if #(.W(GW)) win_if ();
  mac_channel_scheduler_if #(.W(OW)) out_if ();

  logic          wr_en;
  logic [CW-1:0] wr_ch;
  logic [KW-1:0] wr_kernel;
  logic          wr_drop;
  logic [KW-1:0] mac_kernel;
  logic [GW-1:0] mac_grid;
  logic          mac_valid;
  logic [DR-1:0] mac_pixel;
  logic          mac_pixel_valid;
  logic          busy;

  mac_channel_scheduler #(
    .DATA_RES(DR), .WEIGHT_RES(WR), .KERNEL_SIZE(KS), .NUM_CH(NC)
  ) dut (
    .clk_i(clk),
    .resetn_i(resetn),
    .win(win_if),
    .wr_en_i(wr_en),
    .wr_ch_i(wr_ch),
    .wr_kernel_i(wr_kernel),
    .wr_drop_o(wr_drop),
    .mac_kernel_o(mac_kernel),
    .mac_grid_o(mac_grid),
    .mac_valid_o(mac_valid),
    .mac_pixel_i(mac_pixel),
    .mac_pixel_valid_i(mac_pixel_valid),
    .out(out_if),
    .busy_o(busy)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int drops = 0;
  int exp_drops = 0;
  int rdy_mode = 1;
  logic [KW-1:0] bank_m [NC];
  logic [OW-1:0] expq [$];
  int hs_cyc [$];

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Clipped-ReLU of the Q4 dot product; bias slot is not used.
  function automatic logic [DR-1:0] mac_eval(input logic [GW-1:0] g,
                                             input logic [KW-1:0] k);
    int acc;
    acc = 0;
    for (int i = 0; i < KS; i++)
      acc += int'(g[i*DR +: DR]) * int'($signed(k[i*WR +: WR]));
    acc = acc >>> 4;
    if (acc < 0) acc = 0;
    if (acc > 255) acc = 255;
    return DR'(acc);
  endfunction

  function automatic logic [OW-1:0] ref_word(input logic [GW-1:0] w);
    logic [OW-1:0] r;
    r = '0;
    for (int c = 0; c < NC; c++) r[c*DR +: DR] = mac_eval(w, bank_m[c]);
    return r;
  endfunction

  function automatic logic [GW-1:0] rand_win();
    logic [GW-1:0] w;
    for (int i = 0; i < KS; i++) w[i*DR +: DR] = DR'($urandom);
    return w;
  endfunction

  function automatic logic [KW-1:0] rand_kern();
    logic [KW-1:0] k;
    for (int i = 0; i <= KS; i++) k[i*WR +: WR] = WR'($urandom);
    return k;
  endfunction

  function automatic logic [GW-1:0] flat_win(input logic [DR-1:0] p);
    logic [GW-1:0] w;
    for (int i = 0; i < KS; i++) w[i*DR +: DR] = p;
    return w;
  endfunction

  function automatic logic [KW-1:0] spec_kern(input bit centre,
                                              input logic [WR-1:0] v);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < KS; i++)
      if (!centre || i == KS/2) k[i*WR +: WR] = v;
    return k;
  endfunction

  // MAC engine model: kernel register, then three result stages.
  bit [KW-1:0] mk_q;
  bit [DR-1:0] p1, p2, p3;
  bit          v1, v2, v3;
  always @(posedge clk) begin
    mk_q <= mac_kernel;
    v1 <= mac_valid;
    p1 <= mac_valid ? mac_eval(mac_grid, mk_q) : '0;
    v2 <= v1;
    p2 <= p1;
    v3 <= v2;
    p3 <= p2;
  end
  assign mac_pixel = p3;
  assign mac_pixel_valid = v3;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (wr_drop === 1'b1) drops <= drops + 1;

  initial begin
    out_if.ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_if.ready = 1'b0;
        1: out_if.ready = 1'b1;
        default: out_if.ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops one expectation per result handshake.
  always @(negedge clk) begin
    if (out_if.valid === 1'b1 && out_if.ready === 1'b1) begin
      if (expq.size() == 0) begin
        n_chk++;
        $display("FAIL out_unexpected: got %h want none", out_if.data);
      end else begin
        check("out_data", out_if.data, expq.pop_front());
        hs_cyc.push_back(cyc);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (win_if.ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (win_if.ready !== 1'b1) timeout("wait_idle");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 800) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0) timeout("drain");
  endtask

  task automatic send_window(input logic [GW-1:0] w, input bit do_wr,
                             input logic [CW-1:0] ch,
                             input logic [KW-1:0] k, input bit use_ov,
                             input logic [OW-1:0] ov);
    wait_idle();
    if (do_wr) begin
      wr_en = 1'b1;
      wr_ch = ch;
      wr_kernel = k;
      bank_m[ch] = k;
    end
    win_if.data = w;
    win_if.valid = 1'b1;
    expq.push_back(use_ov ? ov : ref_word(w));
    @(posedge clk);
    #1;
    win_if.valid = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic kwrite(input logic [CW-1:0] ch, input logic [KW-1:0] k,
                        input bit exp_drop);
    wr_en = 1'b1;
    wr_ch = ch;
    wr_kernel = k;
    if (exp_drop) exp_drops++;
    else bank_m[ch] = k;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    check("wr_drop", wr_drop, exp_drop);
    @(negedge clk);
    check("wr_drop_end", wr_drop, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ctl"},
          {win_if.ready, out_if.valid, mac_valid, wr_drop, busy}, 0);
    check({tag, "_data"}, out_if.data, 0);
    check({tag, "_kernel"}, mac_kernel, 0);
    check({tag, "_grid"}, mac_grid, 0);
  endtask

  initial begin
    int n;
    int base;
    wr_en = 1'b0;
    wr_ch = '0;
    wr_kernel = '0;
    win_if.valid = 1'b0;
    win_if.data = '0;
    for (int c = 0; c < NC; c++) bank_m[c] = '0;

    #12;
    check_zero_outputs("reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Reference kernels and flat windows.
    kwrite(0, spec_kern(1, 8'h10), 0);
    kwrite(1, spec_kern(0, 8'h10), 0);
    kwrite(2, spec_kern(1, 8'hF0), 0);
    kwrite(3, spec_kern(0, 8'h20), 0);
    send_window(flat_win(8'd10), 0, 0, '0, 1, 32'hB4005A0A);
    send_window(flat_win(8'd200), 0, 0, '0, 1, 32'hFF00FFC8);
    drain();

    // Issue timing and 20 cycles of output backpressure.
    rdy_mode = 0;
    send_window(rand_win(), 0, 0, '0, 0, '0);
    for (int d = 1; d <= NC + 25; d++) begin
      @(negedge clk);
      check("t_mac_valid", mac_valid, (d >= 2 && d <= NC + 1));
      check("t_win_ready", win_if.ready, 0);
      check("t_out_valid", out_if.valid, (d >= NC + 5));
      if (d <= NC) check("t_kernel", mac_kernel, bank_m[d-1]);
      else check("t_kernel_hold", mac_kernel, bank_m[NC-1]);
      if (d >= NC + 6) begin
        check("bp_data", out_if.data, expq[0]);
        check("bp_busy", busy, 1);
      end
    end
    rdy_mode = 1;
    @(negedge clk);
    check("bp_release_ready", win_if.ready, 0);
    @(negedge clk);
    check("bp_after_ready", {win_if.ready, out_if.valid}, 2'b10);

    // Refused writes: during ISSUE and during HOLD.
    send_window(rand_win(), 0, 0, '0, 0, '0);
    kwrite(1, rand_kern(), 1);
    rdy_mode = 0;
    n = 0;
    while (out_if.valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (out_if.valid !== 1'b1) timeout("hold_wait");
    kwrite(2, rand_kern(), 1);
    rdy_mode = 1;
    drain();
    send_window(flat_win(8'd37), 0, 0, '0, 0, '0);
    drain();

    // Reset in the middle of ISSUE.
    send_window(flat_win(8'd99), 0, 0, '0, 0, '0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    resetn = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    expq.delete();
    for (int c = 0; c < NC; c++) bank_m[c] = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_reset_idle", {out_if.valid, busy, mac_valid}, 0);
    end
    send_window(flat_win(8'd77), 0, 0, '0, 0, '0);
    drain();

    // Randomized windows, writes and backpressure.
    wait_idle();
    for (int c = 0; c < NC; c++) kwrite(CW'(c), rand_kern(), 0);
    rdy_mode = 2;
    for (int i = 0; i < 40; i++)
      send_window(rand_win(), 1'($urandom_range(0, 1)),
                  CW'($urandom_range(0, NC-1)), rand_kern(), 0, '0);
    rdy_mode = 1;
    drain();

    // Back-to-back throughput.
    base = hs_cyc.size();
    for (int i = 0; i < 4; i++) send_window(rand_win(), 0, 0, '0, 0, '0);
    drain();
    for (int i = 1; i < 4; i++)
      check("b2b_period", hs_cyc[base+i] - hs_cyc[base+i-1], NC + 6);

    repeat (3) @(negedge clk);
    check("drop_count", drops, exp_drops);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
